sd4_mac_seq: RTL

- Sequencer/accumulator wrapped around the SD4 MAC pipeline (operand stages through the adder-tree stage).
- Paces operand issue with a valid/ready handshake and tracks in-flight products through the fixed-latency pipeline with a valid shift register.
- Accumulates VEC_LEN 20-bit signed sums into a wide dot-product result and presents it on a valid/ready output.
- The MAC pipeline cannot stall, so this block never accepts operands it cannot retire.

---
 rtl/sd4_mac_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sd4_mac_seq.sv
// Sequencer and accumulator for the SD4 MAC pipeline: issues operands, tracks
// in-flight products with a valid shift register and accumulates the tapped sums.
module sd4_mac_seq #(
    parameter int PIPE_LAT = 3,
    parameter int LEN_W    = 8,
    parameter int ACC_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        vec_len,
    input  logic                    abort,
    input  logic                    src_valid,
    output logic                    src_ready,
    input  logic signed [19:0]      sum_in,
    output logic signed [ACC_W-1:0] acc_out,
    output logic                    acc_ovf,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        issued_q, issued_d;
    logic [LEN_W-1:0]        received_q, received_d;
    logic [PIPE_LAT-1:0]     valid_sr_q, valid_sr_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    acc_ovf_q, acc_ovf_d;

    logic                    issue;
    logic                    tap;
    logic signed [ACC_W-1:0] sum_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    ovf_hit;
    logic [LEN_W-1:0]        issued_inc;
    logic [LEN_W-1:0]        received_inc;

    // src_ready depends only on registered state, never on src_valid.
    assign src_ready    = (state_q == RUN) && (issued_q < len_q);
    assign issue        = src_ready && src_valid;
    assign tap          = valid_sr_q[PIPE_LAT-1];
    assign sum_ext      = ACC_W'(sum_in);
    assign acc_sum      = acc_q + sum_ext;
    assign ovf_hit      = (acc_q[ACC_W-1] == sum_ext[ACC_W-1]) &&
                          (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);
    assign issued_inc   = issued_q + LEN_ONE;
    assign received_inc = received_q + LEN_ONE;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case can infer a latch.
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q;
        received_d = received_q;
        valid_sr_d = valid_sr_q;
        acc_d      = acc_q;
        acc_ovf_d  = acc_ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d      = vec_len;
                    issued_d   = '0;
                    received_d = '0;
                    valid_sr_d = '0;
                    acc_d      = '0;
                    acc_ovf_d  = 1'b0;
                    state_d    = (vec_len == '0) ? OUT : RUN;
                end
            end
            RUN, DRAIN: begin
                valid_sr_d = (valid_sr_q << 1) | PIPE_LAT'(issue);
                if (issue) begin
                    issued_d = issued_inc;
                    if (issued_inc == len_q) begin
                        state_d = DRAIN;
                    end
                end
                if (tap) begin
                    acc_d      = acc_sum;
                    acc_ovf_d  = acc_ovf_q | ovf_hit;
                    received_d = received_inc;
                    if (received_inc == len_q) begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase

        // Abort drops in-flight products by clearing their tap bits; acc keeps its value.
        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            issued_d   = '0;
            received_d = '0;
            valid_sr_d = '0;
            acc_d      = acc_q;
            acc_ovf_d  = acc_ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop
        // samples the pre-edge value of every other flop.
        if (rst) begin
            // NOTE: the valid shift register must be reset, otherwise stale X/1 bits
            // would capture garbage into the accumulator after reset.
            state_q    <= IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            received_q <= '0;
            valid_sr_q <= '0;
            acc_q      <= '0;
            acc_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            valid_sr_q <= valid_sr_d;
            acc_q      <= acc_d;
            acc_ovf_q  <= acc_ovf_d;
        end
    end

    assign acc_out   = acc_q;
    assign acc_ovf   = acc_ovf_q;
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);

endmodule
